// File: rtl/fir_out_decimator_pkg.sv
// Shared widths and the round-half-up / clamp helper for the FIR output decimator.
package fir_out_decimator_pkg;

    localparam int IN_W    = 20;
    localparam int OUT_W   = 12;
    localparam int DSEL_W  = 4;
    localparam int ACC_W   = IN_W + DSEL_W;
    localparam int SHIFT_W = 5;

    typedef struct packed {
        logic             sat;
        logic [OUT_W-1:0] value;
    } round_result_t;

    // One extra bit of headroom keeps the rounding bias from wrapping a full-scale sum.
    function automatic round_result_t sat_round(input logic [ACC_W-1:0]   sum,
                                                input logic [SHIFT_W-1:0] s);
        logic [ACC_W:0] bias;
        logic [ACC_W:0] rounded;
        round_result_t  res;
        bias = '0;
        if (s != '0) begin
            bias = (ACC_W+1)'(1) << (s - SHIFT_W'(1));
        end
        rounded   = ({1'b0, sum} + bias) >> s;
        res.sat   = |rounded[ACC_W:OUT_W];
        res.value = res.sat ? '1 : rounded[OUT_W-1:0];
        return res;
    endfunction

endpackage

// File: rtl/fir_out_decimator_sync_fifo2.sv
// Two-entry in-order FIFO; a pop in the same cycle frees the slot for a push even when full.
module fir_out_decimator_sync_fifo2
    import fir_out_decimator_pkg::*;
#(
    parameter int W = OUT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push, do_pop;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fir_out_decimator.sv
// Accumulate-and-dump decimator for the FIR output stream, with rounding, saturation
// and a small output FIFO so the sink can stall without stalling the filter.
module fir_out_decimator
    import fir_out_decimator_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [IN_W-1:0]    in_data,
    input  logic [DSEL_W-1:0]  decim_sel,
    input  logic [SHIFT_W-1:0] shift,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               sat,
    output logic               ovf,
    input  logic               clear_ovf
);

    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [DSEL_W-1:0]  cnt_q, cnt_d;
    logic [DSEL_W-1:0]  n_q, n_d;
    logic [SHIFT_W-1:0] s_q, s_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               dump_q, dump_d;
    logic               ovf_q, ovf_d;

    logic [DSEL_W-1:0]  frame_last;
    logic [ACC_W-1:0]   acc_next;
    round_result_t      rr;
    logic               push, pop, fifo_full, fifo_empty;
    logic [OUT_W-1:0]   fifo_head;

    // The first sample of a frame sees the live config; later samples use the latched copy.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        s_d        = s_q;
        sum_d      = sum_q;
        dump_d     = 1'b0;
        frame_last = (cnt_q == '0) ? decim_sel : n_q;
        acc_next   = acc_q + ACC_W'(in_data);
        if (in_valid) begin
            if (cnt_q == '0) begin
                n_d = decim_sel;
                s_d = shift;
            end
            if (cnt_q == frame_last) begin
                sum_d  = acc_next;
                dump_d = 1'b1;
                acc_d  = '0;
                cnt_d  = '0;
            end else begin
                acc_d = acc_next;
                cnt_d = cnt_q + DSEL_W'(1);
            end
        end
    end

    always_comb begin
        rr    = sat_round(sum_q, s_q);
        push  = dump_q;
        sat   = dump_q & rr.sat;
        pop   = out_ready & ~fifo_empty;
        ovf_d = ovf_q;
        if (push && fifo_full && !pop) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            cnt_q  <= '0;
            n_q    <= '0;
            s_q    <= '0;
            sum_q  <= '0;
            dump_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            n_q    <= n_d;
            s_q    <= s_d;
            sum_q  <= sum_d;
            dump_q <= dump_d;
            ovf_q  <= ovf_d;
        end
    end

    fir_out_decimator_sync_fifo2 #(.W(OUT_W)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (rr.value),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    assign out_valid = ~fifo_empty;
    assign out_data  = fifo_empty ? '0 : fifo_head;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench for fir_out_decimator: frame timing, rounding, saturation, backpressure,
// gaps, mid-frame config change and mid-frame reset.
module tb_fir_out_decimator;
    import fir_out_decimator_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic [IN_W-1:0]    in_data;
    logic [DSEL_W-1:0]  decim_sel;
    logic [SHIFT_W-1:0] shift;
    logic               out_valid;
    logic               out_ready;
    logic [OUT_W-1:0]   out_data;
    logic               sat;
    logic               ovf;
    logic               clear_ovf;

    int vec_count       = 0;
    int miscompare_count = 0;
    int result_count    = 0;

    always #5 clk = ~clk;

    fir_out_decimator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .decim_sel (decim_sel),
        .shift     (shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sat       (sat),
        .ovf       (ovf),
        .clear_ovf (clear_ovf)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [IN_W-1:0] data);
        in_valid = valid;
        in_data  = data;
        @(posedge clk);
        #1;
    endtask

    task automatic sendFrame4(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b,
                              input logic [IN_W-1:0] c, input logic [IN_W-1:0] d,
                              input logic [31:0] expected, input string tag);
        applyStimulus(1'b1, a);
        applyStimulus(1'b1, b);
        applyStimulus(1'b1, c);
        applyStimulus(1'b1, d);
        checkOutput({tag, "_pending"}, out_valid, 0);
        applyStimulus(1'b0, '0);
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput({tag, "_data"}, out_data, expected);
        applyStimulus(1'b0, '0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        decim_sel = '0;
        shift     = '0;
        out_ready = 1'b1;
        clear_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_sat", sat, 0);
        checkOutput("rst_ovf", ovf, 0);
        rst = 1'b0;

        // Steady stream of 100, /4, >>2: a 100 appears two edges after every 4th accept
        decim_sel = 4'd3;
        shift     = 5'd2;
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(k <= 8, 20'd100);
            checkOutput($sformatf("t1_valid_%0d", k), out_valid, (k == 5 || k == 9));
            if (out_valid) begin
                result_count++;
                checkOutput($sformatf("t1_data_%0d", k), out_data, 100);
            end
        end
        checkOutput("t1_result_count", result_count, 2);

        // Rounding
        sendFrame4(20'd1, 20'd1, 20'd1, 20'd0, 1, "t2_sum3");
        sendFrame4(20'd1, 20'd0, 20'd0, 20'd0, 0, "t2_sum1");
        sendFrame4(20'd2, 20'd0, 20'd0, 20'd0, 1, "t2_sum2");
        sendFrame4(20'd6, 20'd0, 20'd0, 20'd0, 2, "t2_sum6");

        // Saturation, /1, no shift
        decim_sel = 4'd0;
        shift     = 5'd0;
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(k <= 3, 20'hFFFFF);
            checkOutput($sformatf("t3_sat_%0d", k), sat, (k <= 3));
            checkOutput($sformatf("t3_valid_%0d", k), out_valid, (k >= 2 && k <= 4));
            if (k >= 2 && k <= 4) begin
                checkOutput($sformatf("t3_data_%0d", k), out_data, 4095);
            end
        end
        checkOutput("t3_ovf", ovf, 0);

        // Backpressure: three frames of 5+5 with the sink stalled
        decim_sel = 4'd1;
        out_ready = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(k <= 6, 20'd5);
            if (k == 5) begin
                checkOutput("t4_ovf_before_drop", ovf, 0);
            end
        end
        checkOutput("t4_ovf_set", ovf, 1);
        checkOutput("t4_held_valid", out_valid, 1);
        checkOutput("t4_held_data", out_data, 10);
        out_ready = 1'b1;
        applyStimulus(1'b0, '0);
        checkOutput("t4_pop1_valid", out_valid, 1);
        checkOutput("t4_pop1_data", out_data, 10);
        checkOutput("t4_ovf_sticky", ovf, 1);
        applyStimulus(1'b0, '0);
        checkOutput("t4_pop2_valid", out_valid, 0);
        checkOutput("t4_empty_data", out_data, 0);
        clear_ovf = 1'b1;
        applyStimulus(1'b0, '0);
        clear_ovf = 1'b0;
        checkOutput("t4_ovf_cleared", ovf, 0);

        // Gaps within a /2 frame
        applyStimulus(1'b1, 20'd3);
        applyStimulus(1'b0, '0);
        applyStimulus(1'b1, 20'd4);
        applyStimulus(1'b0, '0);
        checkOutput("t5_gap_valid", out_valid, 1);
        checkOutput("t5_gap_data", out_data, 7);
        applyStimulus(1'b0, '0);
        checkOutput("t5_gap_popped", out_valid, 0);

        // decim_sel 1->3 mid-frame: current frame ends after 2, next after 4
        applyStimulus(1'b1, 20'd1);
        decim_sel = 4'd3;
        applyStimulus(1'b1, 20'd2);
        checkOutput("t5_cfg_dump_pending", out_valid, 0);
        applyStimulus(1'b1, 20'd1);
        checkOutput("t5_cfg_first_valid", out_valid, 1);
        checkOutput("t5_cfg_first_data", out_data, 3);
        applyStimulus(1'b1, 20'd1);
        checkOutput("t5_cfg_popped", out_valid, 0);
        applyStimulus(1'b1, 20'd1);
        checkOutput("t5_cfg_no_early_dump", out_valid, 0);
        applyStimulus(1'b1, 20'd1);
        checkOutput("t5_cfg_dump_pending2", out_valid, 0);
        applyStimulus(1'b0, '0);
        checkOutput("t5_cfg_second_valid", out_valid, 1);
        checkOutput("t5_cfg_second_data", out_data, 4);
        applyStimulus(1'b0, '0);

        // Reset mid-frame with one result queued
        decim_sel = 4'd1;
        out_ready = 1'b0;
        applyStimulus(1'b1, 20'd7);
        applyStimulus(1'b1, 20'd7);
        applyStimulus(1'b1, 20'd9);
        checkOutput("t6_queued_valid", out_valid, 1);
        checkOutput("t6_queued_data", out_data, 14);
        rst = 1'b1;
        applyStimulus(1'b0, '0);
        rst = 1'b0;
        checkOutput("t6_rst_valid", out_valid, 0);
        checkOutput("t6_rst_data", out_data, 0);
        checkOutput("t6_rst_ovf", ovf, 0);
        out_ready = 1'b1;
        applyStimulus(1'b1, 20'd1);
        applyStimulus(1'b1, 20'd2);
        applyStimulus(1'b0, '0);
        checkOutput("t6_post_valid", out_valid, 1);
        checkOutput("t6_post_data", out_data, 3);
        applyStimulus(1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompare_count);
        $finish;
    end

endmodule
